pwm_brake_ctrl: RTL and testbench

PWM_BRAKE_CTRL -- requirements
Module: pwm_brake_ctrl

---
 rtl/pwm_brake_ctrl.sv | 147 ++++++++++++++
 tb/tb_pwm_brake_ctrl.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_brake_ctrl.sv
// PWM output gating with a filtered external brake and shoot-through trip (RUN/TRIP/ARM).
// Define PWM_BRK_AUTO_REC_EN to compile in automatic recovery from TRIP via auto_rec.
module pwm_brake_ctrl #(
  parameter int FILT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm1_h,
  input  logic              pwm1_l,
  input  logic              pwm2_h,
  input  logic              pwm2_l,
  input  logic              brk_in,
  input  logic              brk_pol,
  input  logic              brk_en,
  input  logic [FILT_W-1:0] filt_len,
  input  logic              clr,
  input  logic              auto_rec,
  input  logic [3:0]        safe_lvl,
  input  logic              period_start,
  output logic              pwm1_h_o,
  output logic              pwm1_l_o,
  output logic              pwm2_h_o,
  output logic              pwm2_l_o,
  output logic              fault,
  output logic [1:0]        cause,
  output logic [1:0]        state
);

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_TRIP = 2'b01,
    ST_ARM  = 2'b10
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_sync1;
  logic              r_sync2;
  logic [FILT_W-1:0] r_filt_cnt;
  logic [FILT_W-1:0] w_eff_len;
  logic              w_brk_act;
  logic              w_brk_trip;
  logic              w_st_trip;
  logic              w_trip;
  logic              w_clr_exit;
  logic              w_auto_exit;
  logic [3:0]        w_pwm_in;
  logic [3:0]        r_out;
  logic              r_fault;
  logic [1:0]        r_cause;

  assign w_pwm_in   = {pwm2_l, pwm2_h, pwm1_l, pwm1_h};
  assign w_brk_act  = ~(r_sync2 ^ brk_pol);
  assign w_eff_len  = (filt_len == '0) ? FILT_W'(1) : filt_len;
  // One extra bit so counter+1 cannot wrap when filt_len is all ones.
  assign w_brk_trip = brk_en & w_brk_act &
                      (({1'b0, r_filt_cnt} + (FILT_W+1)'(1)) >= {1'b0, w_eff_len});
  assign w_st_trip  = (pwm1_h & pwm1_l) | (pwm2_h & pwm2_l);
  assign w_trip     = w_brk_trip | w_st_trip;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_filt_cnt <= '0;
    end else begin
      r_sync1 <= brk_in;
      r_sync2 <= r_sync1;
      if (!w_brk_act)
        r_filt_cnt <= '0;
      else if (r_filt_cnt < filt_len)
        r_filt_cnt <= r_filt_cnt + FILT_W'(1);
    end
  end

`ifdef PWM_BRK_AUTO_REC_EN
  logic [FILT_W-1:0] r_rec_cnt;

  // Counts consecutive inactive-brake cycles spent in TRIP.
  always_ff @(posedge clk) begin
    if (!rst_n)
      r_rec_cnt <= '0;
    else if ((r_state == ST_TRIP) && !w_brk_act) begin
      if (r_rec_cnt < filt_len)
        r_rec_cnt <= r_rec_cnt + FILT_W'(1);
    end else
      r_rec_cnt <= '0;
  end

  assign w_auto_exit = auto_rec & ~w_brk_act & ~w_st_trip &
                       (({1'b0, r_rec_cnt} + (FILT_W+1)'(1)) >= {1'b0, w_eff_len});
`else
  logic w_unused_auto_rec;
  assign w_unused_auto_rec = auto_rec;
  assign w_auto_exit       = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    w_clr_exit = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_trip) w_next = ST_TRIP;
      end
      ST_ARM: begin
        if (w_trip)            w_next = ST_TRIP;
        else if (period_start) w_next = ST_RUN;
      end
      ST_TRIP: begin
        if (clr && !w_brk_act && !w_st_trip) begin
          w_next     = ST_ARM;
          w_clr_exit = 1'b1;
        end else if (w_auto_exit) begin
          w_next = ST_ARM;
        end
      end
      default: w_next = ST_ARM;
    endcase
  end

  // Outputs load from next-state so gating takes effect on the transition edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_ARM;
      r_out   <= 4'b0000;
      r_fault <= 1'b0;
      r_cause <= 2'b00;
    end else begin
      r_state <= w_next;
      r_out   <= (w_next == ST_RUN) ? w_pwm_in : safe_lvl;
      r_fault <= (w_next == ST_TRIP);
      if (w_clr_exit)
        r_cause <= 2'b00;
      else if (w_next == ST_TRIP)
        r_cause <= r_cause | {w_st_trip, w_brk_trip};
    end
  end

  assign pwm1_h_o = r_out[0];
  assign pwm1_l_o = r_out[1];
  assign pwm2_h_o = r_out[2];
  assign pwm2_l_o = r_out[3];
  assign fault    = r_fault;
  assign cause    = r_cause;
  assign state    = r_state;

endmodule

// File: tb/tb_pwm_brake_ctrl.sv
// Bench for pwm_brake_ctrl: directed sequences, a cycle model of the spec rules, literal pins.
// Honours PWM_BRK_AUTO_REC_EN the same way the design does.
module tb_pwm_brake_ctrl;

  localparam logic [1:0] M_RUN  = 2'b00;
  localparam logic [1:0] M_TRIP = 2'b01;
  localparam logic [1:0] M_ARM  = 2'b10;
  localparam logic [3:0] SAFE   = 4'b0101;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       pwm1_h, pwm1_l, pwm2_h, pwm2_l;
  logic       brk_in, brk_pol, brk_en;
  logic [7:0] filt_len;
  logic       clr, auto_rec, period_start;
  logic [3:0] safe_lvl;
  logic       pwm1_h_o, pwm1_l_o, pwm2_h_o, pwm2_l_o;
  logic       fault;
  logic [1:0] cause;
  logic [1:0] state;
  logic [3:0] dut_out;

  assign dut_out = {pwm2_l_o, pwm2_h_o, pwm1_l_o, pwm1_h_o};

  pwm_brake_ctrl #(.FILT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .pwm1_h(pwm1_h), .pwm1_l(pwm1_l), .pwm2_h(pwm2_h), .pwm2_l(pwm2_l),
    .brk_in(brk_in), .brk_pol(brk_pol), .brk_en(brk_en), .filt_len(filt_len),
    .clr(clr), .auto_rec(auto_rec), .safe_lvl(safe_lvl), .period_start(period_start),
    .pwm1_h_o(pwm1_h_o), .pwm1_l_o(pwm1_l_o), .pwm2_h_o(pwm2_h_o), .pwm2_l_o(pwm2_l_o),
    .fault(fault), .cause(cause), .state(state)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver tasks
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pwm(input logic [3:0] p);
    {pwm2_l, pwm2_h, pwm1_l, pwm1_h} = p;
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
  endtask

  task automatic pulse_ps();
    period_start = 1'b1;
    cyc(1);
    period_start = 1'b0;
  endtask

  // Model: brake history, run lengths of active/inactive brake, and the mode rules.
  logic [1:0] m_st;
  logic [3:0] m_out;
  logic       m_fault;
  logic [1:0] m_cause;
  bit         m_valid = 0;
  logic       sync_q[$];
  int         act_run;
  int         quiet_run;

  always @(posedge clk) begin
    int         eff;
    bit         act, st, bt, clr_ok;
    logic [1:0] nst;
    if (!rst_n) begin
      sync_q    = '{1'b0, 1'b0};
      act_run   = 0;
      quiet_run = 0;
      m_st      = M_ARM;
      m_out     = 4'b0000;
      m_fault   = 1'b0;
      m_cause   = 2'b00;
    end else begin
      eff    = (filt_len == 0) ? 1 : int'(filt_len);
      act    = (sync_q[1] == brk_pol);
      st     = (pwm1_h && pwm1_l) || (pwm2_h && pwm2_l);
      bt     = brk_en && act && (act_run + 1 >= eff);
      clr_ok = 0;
      nst    = m_st;
      if (m_st == M_TRIP) begin
        if (clr && !act && !st) begin
          nst    = M_ARM;
          clr_ok = 1;
        end
`ifdef PWM_BRK_AUTO_REC_EN
        else if (auto_rec && !act && !st && (quiet_run + 1 >= eff))
          nst = M_ARM;
`endif
      end else if (bt || st) begin
        nst = M_TRIP;
      end else if (m_st == M_ARM && period_start) begin
        nst = M_RUN;
      end
      if (clr_ok) m_cause = 2'b00;
      else if (nst == M_TRIP) m_cause = m_cause | {st, bt};
      m_out   = (nst == M_RUN) ? {pwm2_l, pwm2_h, pwm1_l, pwm1_h} : safe_lvl;
      m_fault = (nst == M_TRIP);
      act_run   = act ? ((act_run < int'(filt_len)) ? act_run + 1 : act_run) : 0;
      quiet_run = (m_st == M_TRIP && !act) ? quiet_run + 1 : 0;
      m_st = nst;
      sync_q.push_front(brk_in);
      void'(sync_q.pop_back());
    end
    m_valid = 1;
  end

  // scoreboard: compare every cycle once the model has seen a clock edge
  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_state", 32'(state), 32'(m_st));
      chk("model_out",   32'(dut_out), 32'(m_out));
      chk("model_fault", 32'(fault), 32'(m_fault));
      chk("model_cause", 32'(cause), 32'(m_cause));
    end
  end

  logic [3:0] pats [8] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
                           4'b1001, 4'b0110, 4'b1010, 4'b0101};

  initial begin
    rst_n = 1'b0; set_pwm(4'b0000);
    brk_in = 1'b0; brk_pol = 1'b1; brk_en = 1'b1; filt_len = 8'd3;
    clr = 1'b0; auto_rec = 1'b0; period_start = 1'b0; safe_lvl = SAFE;
    cyc(2);
    chk("rst_state", 32'(state), 32'(M_ARM));
    chk("rst_out",   32'(dut_out), 32'h0);
    chk("rst_fault", 32'(fault), 32'h0);
    chk("rst_cause", 32'(cause), 32'h0);

    // ARM after reset, period_start in cycle 5, pwm1_h toggling
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      pwm1_h = i[0];
      period_start = (i == 5);
      cyc(1);
      if (i < 5) chk("arm_safe", 32'(dut_out), 32'(SAFE));
      else       chk("run_follow", 32'(pwm1_h_o), 32'(i[0]));
    end
    period_start = 1'b0;
    chk("run_entered", 32'(state), 32'(M_RUN));

    foreach (pats[k]) begin
      set_pwm(pats[k]);
      cyc(1);
      chk("pass_through", 32'(dut_out), 32'(pats[k]));
    end
    set_pwm(4'b0000);

    // short brake pulse does not trip; held pulse trips at edge 2+filt_len
    brk_in = 1'b1; cyc(2); brk_in = 1'b0; cyc(5);
    chk("short_pulse", 32'(state), 32'(M_RUN));
    brk_in = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
      chk("brk_latency", 32'(state), 32'((k < 5) ? M_RUN : M_TRIP));
    end
    chk("brk_cause", 32'(cause), 32'h1);
    chk("brk_fault", 32'(fault), 32'h1);
    chk("brk_safe",  32'(dut_out), 32'(SAFE));

    // clr ignored while brake active; accepted after release
    pulse_clr();
    chk("clr_blocked", 32'(state), 32'(M_TRIP));
    brk_in = 1'b0; cyc(3);
    pulse_clr();
    chk("clr_to_arm", 32'(state), 32'(M_ARM));
    chk("clr_cause",  32'(cause), 32'h0);
    pulse_clr();
    chk("clr_in_arm", 32'(state), 32'(M_ARM));
    pulse_ps();
    chk("arm_to_run", 32'(state), 32'(M_RUN));
    pulse_clr();
    chk("clr_in_run", 32'(state), 32'(M_RUN));

    // shoot-through on pair 1 with brake disabled
    brk_en = 1'b0;
    set_pwm(4'b0011); cyc(1); set_pwm(4'b0000);
    chk("st1_state", 32'(state), 32'(M_TRIP));
    chk("st1_cause", 32'(cause), 32'h2);
    chk("st1_out",   32'(dut_out), 32'(SAFE));
    cyc(2);
    pulse_clr();
    chk("st1_clr", 32'(state), 32'(M_ARM));
    brk_en = 1'b1;

    // shoot-through on pair 2 beats period_start in ARM
    set_pwm(4'b1100); period_start = 1'b1; cyc(1);
    set_pwm(4'b0000); period_start = 1'b0;
    chk("st2_over_ps", 32'(state), 32'(M_TRIP));
    chk("st2_cause",   32'(cause), 32'h2);
    pulse_clr();

    // filt_len=0 acts as 1; brake trip beats period_start in ARM
    filt_len = 8'd0; brk_in = 1'b1; cyc(2);
    chk("len0_wait", 32'(state), 32'(M_ARM));
    pulse_ps();
    chk("brk_over_ps", 32'(state), 32'(M_TRIP));
    chk("len0_cause",  32'(cause), 32'h1);
    brk_in = 1'b0; cyc(3); pulse_clr();

    // filt_len lowered mid-count takes effect on the next comparison
    pulse_ps();
    filt_len = 8'd6; brk_in = 1'b1; cyc(4);
    chk("mid_len_run", 32'(state), 32'(M_RUN));
    filt_len = 8'd3; cyc(1);
    chk("mid_len_trip", 32'(state), 32'(M_TRIP));
    brk_in = 1'b0; cyc(3); pulse_clr();

    // auto recovery after filt_len inactive cycles
    filt_len = 8'd4; auto_rec = 1'b1;
    pulse_ps();
    brk_in = 1'b1; cyc(6);
    chk("auto_trip", 32'(state), 32'(M_TRIP));
    brk_in = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      cyc(1);
`ifdef PWM_BRK_AUTO_REC_EN
      chk("auto_rec", 32'(state), 32'((k < 6) ? M_TRIP : M_ARM));
`else
      chk("no_auto_rec", 32'(state), 32'(M_TRIP));
`endif
    end
`ifdef PWM_BRK_AUTO_REC_EN
    chk("auto_cause_kept", 32'(cause), 32'h1);
`else
    pulse_clr();
    chk("manual_clr", 32'(state), 32'(M_ARM));
`endif
    auto_rec = 1'b0;

    // reset in TRIP discards the fault
    set_pwm(4'b0011); cyc(1); set_pwm(4'b0000);
    chk("pre_rst_trip", 32'(state), 32'(M_TRIP));
    rst_n = 1'b0; cyc(1);
    chk("rst_trip_state", 32'(state), 32'(M_ARM));
    chk("rst_trip_cause", 32'(cause), 32'h0);
    chk("rst_trip_fault", 32'(fault), 32'h0);
    rst_n = 1'b1; cyc(1);
    chk("post_rst_safe", 32'(dut_out), 32'(SAFE));
    cyc(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
